// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and branch/mispredict statistics.
// Optional macro BRANCH_PRED_GSHARE_EN moves the counters into a gshare pattern table.
module branch_predictor #(
    parameter int ENTRIES  = 64,
    parameter int IDX_BITS = $clog2(ENTRIES),
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    output logic        pred_taken_f,
    output logic [31:0] pred_pc_f,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_is_jump,
    input  logic        upd_mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    logic                valid_q   [ENTRIES];
    logic [TAG_BITS-1:0] tag_q     [ENTRIES];
    logic [31:0]         target_q  [ENTRIES];
    logic                is_jump_q [ENTRIES];

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                f_hit, u_hit;
    logic [1:0]          f_ctr, u_ctr, u_ctr_d;
    logic                unused_pc_lsbs;

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? 2'b11 : c + 2'd1;
        else    return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    assign f_idx = pc_f[IDX_BITS+1:2];
    assign f_tag = pc_f[31:IDX_BITS+2];
    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign u_tag = upd_pc[31:IDX_BITS+2];
    assign unused_pc_lsbs = ^{pc_f[1:0], upd_pc[1:0]};

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr_d = sat_ctr(u_ctr, upd_taken);

`ifdef BRANCH_PRED_GSHARE_EN
    logic [1:0]          pht_q [ENTRIES];
    logic [IDX_BITS-1:0] ghr_q;

    assign f_ctr = pht_q[f_idx ^ ghr_q];
    assign u_ctr = pht_q[u_idx ^ ghr_q];

    // Jumps neither train the pattern table nor shift history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
        end else if (upd_valid && !upd_is_jump) begin
            pht_q[u_idx ^ ghr_q] <= u_ctr_d;
            ghr_q <= {ghr_q[IDX_BITS-2:0], upd_taken};
        end
    end
`else
    logic [1:0] ctr_q [ENTRIES];

    assign f_ctr = ctr_q[f_idx];
    assign u_ctr = ctr_q[u_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (upd_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= upd_is_jump ? 2'b11 : u_ctr_d;
            end else if (upd_taken) begin
                ctr_q[u_idx] <= upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end
`endif

    // Lookup sees pre-update contents; reset forces the fall-through path.
    always_comb begin
        pred_taken_f = rst_n && f_hit && (is_jump_q[f_idx] || f_ctr[1]);
        pred_pc_f    = pred_taken_f ? target_q[f_idx] : pc_f + 32'd4;
    end

    // A not-taken miss leaves the aliasing entry untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                is_jump_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) target_q[u_idx] <= upd_target;
                is_jump_q[u_idx] <= upd_is_jump;
            end else if (upd_taken) begin
                valid_q[u_idx]   <= 1'b1;
                tag_q[u_idx]     <= u_tag;
                target_q[u_idx]  <= upd_target;
                is_jump_q[u_idx] <= upd_is_jump;
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd_valid) begin
            branch_count_d = branch_count_q + 32'd1;
            if (upd_mispredict) mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic against a table model.
module tb_branch_predictor;

    localparam int ENT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_f = 32'h0;
    logic        pred_taken_f;
    logic [31:0] pred_pc_f;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_is_jump = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    // Reference model: one record per index, counter kept as an integer 0..3.
    bit          m_valid [ENT];
    bit   [31:0] m_key   [ENT];
    bit   [31:0] m_tgt   [ENT];
    bit          m_jump  [ENT];
    int          m_ctr   [ENT];
    bit   [31:0] m_bcnt, m_mcnt;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f), .pred_pc_f(pred_pc_f),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_is_jump(upd_is_jump),
        .upd_mispredict(upd_mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_key[i] = 0; m_tgt[i] = 0; m_jump[i] = 0; m_ctr[i] = 1;
        end
        m_bcnt = 0; m_mcnt = 0;
    endfunction

    function automatic void model_predict(input bit [31:0] pc, output bit t, output bit [31:0] npc);
        int idx = int'((pc / 4) % ENT);
        bit hit = m_valid[idx] && (m_key[idx] == pc / (4 * ENT));
        t   = hit && (m_jump[idx] || m_ctr[idx] >= 2);
        npc = t ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic void model_update(input bit [31:0] pc, input bit tk, input bit [31:0] tgt,
                                         input bit jmp, input bit mis);
        int idx = int'((pc / 4) % ENT);
        bit hit = m_valid[idx] && (m_key[idx] == pc / (4 * ENT));
        m_bcnt = m_bcnt + 1;
        if (mis) m_mcnt = m_mcnt + 1;
        if (hit) begin
            if (tk) m_tgt[idx] = tgt;
            m_jump[idx] = jmp;
            if (jmp) m_ctr[idx] = 3;
            else if (tk) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
            else m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end else if (tk) begin
            m_valid[idx] = 1; m_key[idx] = pc / (4 * ENT); m_tgt[idx] = tgt;
            m_jump[idx] = jmp; m_ctr[idx] = jmp ? 3 : 2;
        end
    endfunction

    // Presents one update for a single cycle, just after a rising edge.
    task automatic do_update(input bit [31:0] pc, input bit tk, input bit [31:0] tgt,
                             input bit jmp, input bit mis);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_is_jump = jmp; upd_mispredict = mis;
        @(posedge clk); #1;
        model_update(pc, tk, tgt, jmp, mis);
        upd_valid = 0; upd_mispredict = 0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0; pc_f = 32'h100;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (pred_taken_f !== 1'b0 || pred_pc_f !== 32'h104) begin
            errors++; $display("FAIL reset_lookup: got %b/%h want 0/00000104", pred_taken_f, pred_pc_f);
        end
        checks++;
        if (branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", branch_count, mispredict_count);
        end
        rst_n = 1;
        @(posedge clk); #1;
        pc_f = 32'hFFFF_FFFC; #1;
        checks++;
        if (pred_taken_f !== 1'b0 || pred_pc_f !== 32'h0) begin
            errors++; $display("FAIL pc_wrap: got %b/%h want 0/00000000", pred_taken_f, pred_pc_f);
        end
    endtask

    task automatic test_basic_alloc();
        pc_f = 32'h100;
        upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h80; upd_is_jump = 0;
        #1;
        checks++;
        if (pred_taken_f !== 1'b0 || pred_pc_f !== 32'h104) begin
            errors++; $display("FAIL same_cycle_old: got %b/%h want 0/00000104", pred_taken_f, pred_pc_f);
        end
        @(posedge clk); #1;
        model_update(32'h100, 1, 32'h80, 0, 0);
        upd_valid = 0;
        checks++;
        if (pred_taken_f !== 1'b1 || pred_pc_f !== 32'h80) begin
            errors++; $display("FAIL alloc_taken: got %b/%h want 1/00000080", pred_taken_f, pred_pc_f);
        end
    endtask

    task automatic test_saturation();
        // Directions applied in order, with the prediction required after each step.
        bit dir  [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
        bit want [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        pc_f = 32'h100;
        for (int i = 0; i < 9; i++) begin
            do_update(32'h100, dir[i], 32'h80, 0, 0);
            checks++;
            if (pred_taken_f !== want[i] || pred_pc_f !== (want[i] ? 32'h80 : 32'h104)) begin
                errors++;
                $display("FAIL saturate_step%0d: got %b/%h want %b", i, pred_taken_f, pred_pc_f, want[i]);
            end
        end
    endtask

    task automatic test_alias_jump();
        pc_f = 32'h200; #1;
        checks++;
        if (pred_taken_f !== 1'b0 || pred_pc_f !== 32'h204) begin
            errors++; $display("FAIL alias_miss: got %b/%h want 0/00000204", pred_taken_f, pred_pc_f);
        end
        do_update(32'h200, 1, 32'h300, 0, 0);
        checks++;
        if (pred_taken_f !== 1'b1 || pred_pc_f !== 32'h300) begin
            errors++; $display("FAIL alias_replace: got %b/%h want 1/00000300", pred_taken_f, pred_pc_f);
        end
        pc_f = 32'h100; #1;
        checks++;
        if (pred_taken_f !== 1'b0 || pred_pc_f !== 32'h104) begin
            errors++; $display("FAIL alias_evicted: got %b/%h want 0/00000104", pred_taken_f, pred_pc_f);
        end
        do_update(32'h500, 0, 32'h700, 0, 0);
        pc_f = 32'h200; #1;
        checks++;
        if (pred_taken_f !== 1'b1 || pred_pc_f !== 32'h300) begin
            errors++; $display("FAIL nt_miss_noop: got %b/%h want 1/00000300", pred_taken_f, pred_pc_f);
        end
        pc_f = 32'h40;
        do_update(32'h40, 1, 32'h1000, 1, 0);
        do_update(32'h40, 0, 32'h2000, 1, 0);
        do_update(32'h40, 0, 32'h2000, 1, 0);
        checks++;
        if (pred_taken_f !== 1'b1 || pred_pc_f !== 32'h1000) begin
            errors++; $display("FAIL jump_sticky: got %b/%h want 1/00001000", pred_taken_f, pred_pc_f);
        end
    endtask

    task automatic test_stats();
        bit [31:0] b0 = m_bcnt, m0 = m_mcnt;
        do_update(32'h40, 1, 32'h1000, 1, 0);
        do_update(32'h200, 1, 32'h300, 0, 1);
        do_update(32'h200, 1, 32'h300, 0, 0);
        checks++;
        if (branch_count !== b0 + 3 || mispredict_count !== m0 + 1) begin
            errors++;
            $display("FAIL stats: got %0d/%0d want %0d/%0d", branch_count, mispredict_count, b0 + 3, m0 + 1);
        end
    endtask

    task automatic test_async_reset();
        pc_f = 32'h200;
        @(negedge clk); #2;
        rst_n = 0; model_reset(); #1;
        checks++;
        if (branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
            errors++; $display("FAIL async_counters: got %0d/%0d want 0/0", branch_count, mispredict_count);
        end
        checks++;
        if (pred_taken_f !== 1'b0 || pred_pc_f !== 32'h204) begin
            errors++; $display("FAIL async_lookup: got %b/%h want 0/00000204", pred_taken_f, pred_pc_f);
        end
        upd_valid = 1; upd_pc = 32'h200; upd_taken = 1; upd_target = 32'h900; upd_is_jump = 1;
        upd_mispredict = 1;
        @(posedge clk); #1;
        upd_valid = 0; upd_mispredict = 0;
        checks++;
        if (pred_taken_f !== 1'b0 || branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
            errors++; $display("FAIL reset_ignores_upd: got %b/%0d/%0d want 0/0/0",
                               pred_taken_f, branch_count, mispredict_count);
        end
        rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (pred_taken_f !== 1'b0 || pred_pc_f !== 32'h204) begin
            errors++; $display("FAIL post_reset_lookup: got %b/%h want 0/00000204", pred_taken_f, pred_pc_f);
        end
    endtask

    task automatic test_random();
        bit        et;
        bit [31:0] ep;
        for (int n = 0; n < 400; n++) begin
            bit [31:0] lpc = {$urandom_range(0, 3) == 3 ? 24'hFFFFFF : 24'(32'($urandom_range(0, 2))),
                              6'($urandom_range(0, 7)), 2'b00};
            bit [31:0] upc = {24'(32'($urandom_range(0, 2))), 6'($urandom_range(0, 7)), 2'b00};
            bit        v   = ($urandom_range(0, 9) < 7);
            bit        tk  = $urandom_range(0, 1) == 1;
            bit        jmp = $urandom_range(0, 5) == 0;
            bit        mis = $urandom_range(0, 3) == 0;
            bit [31:0] tgt = $urandom & 32'hFFFF_FFFC;
            pc_f = lpc;
            upd_valid = v; upd_pc = upc; upd_taken = tk; upd_target = tgt;
            upd_is_jump = jmp; upd_mispredict = mis;
            #1;
            model_predict(lpc, et, ep);
            checks++;
            if (pred_taken_f !== et || pred_pc_f !== ep) begin
                errors++;
                $display("FAIL rand_lookup[%0d] pc=%h: got %b/%h want %b/%h", n, lpc, pred_taken_f,
                         pred_pc_f, et, ep);
            end
            @(posedge clk); #1;
            if (v) model_update(upc, tk, tgt, jmp, mis);
            upd_valid = 0; upd_mispredict = 0;
            checks++;
            if (branch_count !== m_bcnt || mispredict_count !== m_mcnt) begin
                errors++;
                $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d", n, branch_count,
                         mispredict_count, m_bcnt, m_mcnt);
            end
        end
    endtask

`ifdef BRANCH_PRED_GSHARE_EN
    task automatic test_gshare();
        // History after four taken branches is 0x0F; index 0 ^ 0x0F is still the reset value 01.
        pc_f = 32'h100;
        for (int i = 0; i < 4; i++) do_update(32'h100, 1, 32'h80, 0, 0);
        checks++;
        if (pred_taken_f !== 1'b0 || pred_pc_f !== 32'h104) begin
            errors++; $display("FAIL gshare_pht: got %b/%h want 0/00000104", pred_taken_f, pred_pc_f);
        end
        do_update(32'h100, 0, 32'h80, 0, 0);
        checks++;
        if (branch_count !== 32'd5) begin
            errors++; $display("FAIL gshare_stats: got %0d want 5", branch_count);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef BRANCH_PRED_GSHARE_EN
        test_gshare();
`else
        test_basic_alloc();
        test_saturation();
        test_alias_jump();
        test_stats();
        test_async_reset();
        test_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
